// File: rtl/cfg_bus_arbiter.sv
// cfg_bus_arbiter: shares the register-bank port between the Wishbone slave
// and the SPI host word interface. Round-robin arbitration, one access at a time.
// Optional build macro: CFG_ARB_TIMEOUT_EN (reg_ready timeout with sticky arb_err).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no access in flight; arbitrate between wb_req and spi_req
// ST_ACCESS | reg_en held high with latched fields until reg_ready/timeout
// ST_RESP   | one-cycle ack (WB) or done (SPI) pulse, then back to IDLE
module cfg_bus_arbiter #(
  parameter int unsigned ADDR_W    = 6,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              spi_req,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [31:0]       spi_wdata,
  output logic              spi_done,
  output logic [31:0]       spi_rdata,
  output logic              reg_en,
  output logic              reg_we,
  output logic [3:0]        reg_be,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  input  logic [31:0]       reg_rdata,
  input  logic              reg_ready,
  output logic              arb_busy,
  output logic              arb_owner,
  output logic              arb_err
);

  localparam logic OWN_WB  = 1'b0;
  localparam logic OWN_SPI = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic              owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              reg_en_q, reg_en_d;
  logic              reg_we_q, reg_we_d;
  logic [3:0]        reg_be_q, reg_be_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [31:0]       reg_wdata_q, reg_wdata_d;
  logic              wb_ack_q, wb_ack_d;
  logic [31:0]       wb_dat_q, wb_dat_d;
  logic              spi_done_q, spi_done_d;
  logic [31:0]       spi_rdata_q, spi_rdata_d;
  logic              wb_abort_q, wb_abort_d;

  logic        wb_hit;
  logic        wb_req;
  logic        grant_spi;
  logic        tmo_hit;
  logic        wb_abort_now;
  logic [31:0] rsp_data;
  logic        unused_bits;

  assign wb_hit       = (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign wb_req       = wbs_cyc_i & wbs_stb_i & wb_hit;
  // SPI wins only when WB is absent or WB had the last grant.
  assign grant_spi    = spi_req & (~wb_req | (rr_last_q == OWN_WB));
  assign wb_abort_now = wb_abort_q | ~wbs_cyc_i;
  // On timeout reg_ready is low, so the marker pattern is returned instead.
  assign rsp_data     = reg_ready ? reg_rdata : 32'hDEAD_BEEF;
  assign unused_bits  = ^{wbs_adr_i[1:0], (TIMEOUT != 0)};

`ifdef CFG_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic             arb_err_q, arb_err_d;

  assign tmo_inc = tmo_cnt_q + TMO_W'(1);
  assign tmo_hit = (state_q == ST_ACCESS) && !reg_ready && (tmo_inc == TMO_W'(TIMEOUT));
  assign arb_err = arb_err_q;

  // Wait counter: held at zero outside ACCESS, counts cycles without reg_ready.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    arb_err_d = arb_err_q;
    if (state_q != ST_ACCESS) begin
      tmo_cnt_d = '0;
    end else if (!reg_ready) begin
      tmo_cnt_d = tmo_inc;
    end
    if (tmo_hit) begin
      arb_err_d = 1'b1;
    end
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tmo_cnt_q <= '0;
      arb_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      arb_err_q <= arb_err_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign arb_err = 1'b0;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    reg_en_d    = reg_en_q;
    reg_we_d    = reg_we_q;
    reg_be_d    = reg_be_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    wb_ack_d    = 1'b0;
    wb_dat_d    = wb_dat_q;
    spi_done_d  = 1'b0;
    spi_rdata_d = spi_rdata_q;
    wb_abort_d  = wb_abort_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_req || spi_req) begin
          state_d    = ST_ACCESS;
          busy_d     = 1'b1;
          reg_en_d   = 1'b1;
          owner_d    = grant_spi;
          rr_last_d  = grant_spi;
          wb_abort_d = 1'b0;
          if (grant_spi) begin
            reg_we_d    = spi_we;
            reg_be_d    = 4'hF;
            reg_addr_d  = spi_addr;
            reg_wdata_d = spi_wdata;
          end else begin
            reg_we_d    = wbs_we_i;
            reg_be_d    = wbs_sel_i;
            reg_addr_d  = wbs_adr_i[ADDR_W+1:2];
            reg_wdata_d = wbs_dat_i;
          end
        end
      end
      ST_ACCESS: begin
        // A WB master that lets go of cyc still gets its access, but no ack.
        if ((owner_q == OWN_WB) && !wbs_cyc_i) begin
          wb_abort_d = 1'b1;
        end
        if (reg_ready || tmo_hit) begin
          state_d  = ST_RESP;
          reg_en_d = 1'b0;
          if (owner_q == OWN_SPI) begin
            spi_done_d  = 1'b1;
            spi_rdata_d = rsp_data;
          end else if (!wb_abort_now) begin
            wb_ack_d = 1'b1;
            wb_dat_d = rsp_data;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        reg_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= OWN_SPI;
      owner_q     <= OWN_WB;
      busy_q      <= 1'b0;
      reg_en_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_be_q    <= 4'h0;
      reg_addr_q  <= '0;
      reg_wdata_q <= 32'h0;
      wb_ack_q    <= 1'b0;
      wb_dat_q    <= 32'h0;
      spi_done_q  <= 1'b0;
      spi_rdata_q <= 32'h0;
      wb_abort_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      reg_en_q    <= reg_en_d;
      reg_we_q    <= reg_we_d;
      reg_be_q    <= reg_be_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      wb_ack_q    <= wb_ack_d;
      wb_dat_q    <= wb_dat_d;
      spi_done_q  <= spi_done_d;
      spi_rdata_q <= spi_rdata_d;
      wb_abort_q  <= wb_abort_d;
    end
  end

  assign wbs_ack_o = wb_ack_q;
  assign wbs_dat_o = wb_dat_q;
  assign spi_done  = spi_done_q;
  assign spi_rdata = spi_rdata_q;
  assign reg_en    = reg_en_q;
  assign reg_we    = reg_we_q;
  assign reg_be    = reg_be_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign arb_busy  = busy_q;
  assign arb_owner = owner_q;

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Bench for cfg_bus_arbiter: directed steps, a behavioural register bank,
// and a response scoreboard fed in stimulus order.
module tb_cfg_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        spi_req, spi_we;
  logic [5:0]  spi_addr;
  logic [31:0] spi_wdata;
  logic        spi_done;
  logic [31:0] spi_rdata;
  logic        reg_en, reg_we;
  logic [3:0]  reg_be;
  logic [5:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        reg_ready;
  logic        arb_busy, arb_owner, arb_err;

  int total = 0;
  int bad = 0;
  int ready_dly = 0;
  int en_cnt = 0;

  typedef struct {
    logic        owner;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];

  cfg_bus_arbiter #(
    .ADDR_W(6), .BASE_ADDR(32'h3000_0000), .TIMEOUT(4)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_done(spi_done), .spi_rdata(spi_rdata),
    .reg_en(reg_en), .reg_we(reg_we), .reg_be(reg_be), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ready(reg_ready),
    .arb_busy(arb_busy), .arb_owner(arb_owner), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  // Register bank model: read data encodes the address; ready after ready_dly cycles of reg_en.
  always @(posedge clk) en_cnt <= reg_en ? en_cnt + 1 : 0;
  assign reg_ready = reg_en && (en_cnt >= ready_dly);
  assign reg_rdata = 32'hCAFE_0000 | {26'd0, reg_addr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic o, input logic we, input logic [5:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input logic [31:0] rd);
    exp_t e;
    e.owner = o; e.we = we; e.addr = a; e.wdata = wd; e.be = be; e.rdata = rd;
    q.push_back(e);
  endtask

  task automatic wait_rsp(input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wbs_ack_o || spi_done) && n < max_cyc);
    chk("rsp_seen", {31'd0, wbs_ack_o | spi_done}, 32'd1);
  endtask

  task automatic wb_drive(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                          input logic [3:0] sel);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
  endtask

  task automatic wb_idle();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  // Scoreboard: field check at the accepted access, data/owner check at the response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_en && reg_ready && q.size() > 0) begin
        chk("acc_owner", {31'd0, arb_owner}, {31'd0, q[0].owner});
        chk("acc_we", {31'd0, reg_we}, {31'd0, q[0].we});
        chk("acc_addr", {26'd0, reg_addr}, {26'd0, q[0].addr});
        chk("acc_wdata", reg_wdata, q[0].wdata);
        chk("acc_be", {28'd0, reg_be}, {28'd0, q[0].be});
      end
      if (wbs_ack_o || spi_done) begin
        if (q.size() == 0) begin
          chk("spurious_rsp", {30'd0, wbs_ack_o, spi_done}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_excl", {31'd0, wbs_ack_o & spi_done}, 32'd0);
          chk("rsp_owner", {31'd0, spi_done}, {31'd0, e.owner});
          chk("rsp_data", spi_done ? spi_rdata : wbs_dat_o, e.rdata);
        end
      end
    end
  end

  initial begin
    int n;
    logic seen;
    logic [31:0] miss_adr [2];
    miss_adr[0] = 32'h2000_0000;
    miss_adr[1] = 32'h3000_0100;

    rst_n = 1'b0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    spi_req = 0; spi_we = 0; spi_addr = 0; spi_wdata = 0;

    // Reset values
    @(negedge clk);
    chk("rst_outs", {wbs_ack_o, spi_done, reg_en, reg_we, reg_be, arb_busy, arb_owner, arb_err},
        32'd0);
    chk("rst_wbdat", wbs_dat_o, 32'd0);
    chk("rst_spidat", spi_rdata, 32'd0);
    chk("rst_regaddr", {26'd0, reg_addr}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // WB write, minimum latency
    @(posedge clk); #1;
    ready_dly = 0;
    wb_drive(32'h3000_0008, 1'b1, 32'h1234_5678, 4'b0011);
    push_exp(1'b0, 1'b1, 6'd2, 32'h1234_5678, 4'b0011, 32'hCAFE_0002);
    @(negedge clk);
    chk("t1_c0_en", {31'd0, reg_en}, 32'd0);
    @(negedge clk);
    chk("t1_c1_en", {31'd0, reg_en}, 32'd1);
    chk("t1_addr", {26'd0, reg_addr}, 32'd2);
    chk("t1_be", {28'd0, reg_be}, 32'h3);
    chk("t1_we", {31'd0, reg_we}, 32'd1);
    chk("t1_wdata", reg_wdata, 32'h1234_5678);
    chk("t1_busy", {31'd0, arb_busy}, 32'd1);
    chk("t1_c1_ack", {31'd0, wbs_ack_o}, 32'd0);
    @(negedge clk);
    chk("t1_c2_ack", {31'd0, wbs_ack_o}, 32'd1);
    chk("t1_c2_en", {31'd0, reg_en}, 32'd0);
    @(posedge clk); #1 wb_idle();
    @(negedge clk);
    chk("t1_c3_ack", {31'd0, wbs_ack_o}, 32'd0);
    chk("t1_c3_busy", {31'd0, arb_busy}, 32'd0);

    // SPI read, reg_ready delayed 3 cycles
    @(posedge clk); #1;
    ready_dly = 3;
    spi_req = 1'b1; spi_we = 1'b0; spi_addr = 6'd5; spi_wdata = 32'd0;
    push_exp(1'b1, 1'b0, 6'd5, 32'd0, 4'hF, 32'hCAFE_0005);
    wait_rsp(20, n);
    chk("t2_latency", n, 32'd6);
    chk("t2_noack", {31'd0, wbs_ack_o}, 32'd0);
    @(posedge clk); #1 spi_req = 1'b0;
    @(negedge clk);
    chk("t2_done_pulse", {31'd0, spi_done}, 32'd0);
    chk("t2_rdata_hold", spi_rdata, 32'hCAFE_0005);

    // WB master abandons during ACCESS: access completes, no ack
    @(posedge clk); #1;
    wb_drive(32'h3000_0018, 1'b0, 32'd0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("ab_wb_en", {31'd0, reg_en}, 32'd1);
    @(posedge clk); #1 wb_idle();
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | wbs_ack_o;
    end
    chk("ab_wb_noack", {31'd0, seen}, 32'd0);
    chk("ab_wb_idle", {31'd0, arb_busy}, 32'd0);
    chk("ab_wb_dathold", wbs_dat_o, 32'hCAFE_0002);

    // SPI drops request during ACCESS: done still issued
    @(posedge clk); #1;
    ready_dly = 2;
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 6'd12; spi_wdata = 32'h0BAD_F00D;
    push_exp(1'b1, 1'b1, 6'd12, 32'h0BAD_F00D, 4'hF, 32'hCAFE_000C);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 spi_req = 1'b0;
    wait_rsp(10, n);

    // Both requesting continuously from reset: WB, SPI, WB, SPI
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    ready_dly = 0;
    wb_drive(32'h3000_0010, 1'b0, 32'd0, 4'hF);
    spi_req = 1'b1; spi_we = 1'b0; spi_addr = 6'd7; spi_wdata = 32'd0;
    for (int i = 0; i < 2; i++) begin
      push_exp(1'b0, 1'b0, 6'd4, 32'd0, 4'hF, 32'hCAFE_0004);
      push_exp(1'b1, 1'b0, 6'd7, 32'd0, 4'hF, 32'hCAFE_0007);
    end
    for (int i = 0; i < 4; i++) begin
      wait_rsp(10, n);
      chk("rr_gap", n, 32'd3);
    end
    @(posedge clk); #1;
    wb_idle();
    spi_req = 1'b0;
    @(negedge clk);
    chk("rr_end_busy", {31'd0, arb_busy}, 32'd0);

    // Address misses, including first address above the window
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      wb_drive(miss_adr[k], 1'b1, 32'hFFFF_FFFF, 4'hF);
      seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        seen = seen | reg_en | arb_busy | wbs_ack_o;
      end
      chk("miss_quiet", {31'd0, seen}, 32'd0);
      @(posedge clk); #1 wb_idle();
    end

    // Asynchronous reset mid-ACCESS, then a fresh SPI write
    @(posedge clk); #1;
    ready_dly = 10;
    wb_drive(32'h3000_0004, 1'b1, 32'h5555_AAAA, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("ar_pre_en", {31'd0, reg_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_en", {31'd0, reg_en}, 32'd0);
    chk("ar_busy", {31'd0, arb_busy}, 32'd0);
    chk("ar_ack", {31'd0, wbs_ack_o}, 32'd0);
    @(posedge clk); #1 wb_idle();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    ready_dly = 1;
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 6'd9; spi_wdata = 32'hA5A5_0009;
    push_exp(1'b1, 1'b1, 6'd9, 32'hA5A5_0009, 4'hF, 32'hCAFE_0009);
    wait_rsp(10, n);
    chk("ar_spi_lat", n, 32'd4);
    chk("ar_err_clear", {31'd0, arb_err}, 32'd0);
    @(posedge clk); #1 spi_req = 1'b0;

`ifdef CFG_ARB_TIMEOUT_EN
    // reg_ready never arrives: timeout after 4 ACCESS cycles
    @(posedge clk); #1;
    ready_dly = 1000;
    wb_drive(32'h3000_0004, 1'b0, 32'd0, 4'hF);
    push_exp(1'b0, 1'b0, 6'd1, 32'd0, 4'hF, 32'hDEAD_BEEF);
    wait_rsp(20, n);
    chk("to_latency", n, 32'd6);
    chk("to_dat", wbs_dat_o, 32'hDEAD_BEEF);
    chk("to_err", {31'd0, arb_err}, 32'd1);
    @(posedge clk); #1 wb_idle();
    @(posedge clk); #1;
    ready_dly = 0;
    wb_drive(32'h3000_000C, 1'b0, 32'd0, 4'hF);
    push_exp(1'b0, 1'b0, 6'd3, 32'd0, 4'hF, 32'hCAFE_0003);
    wait_rsp(10, n);
    chk("to_err_sticky", {31'd0, arb_err}, 32'd1);
    @(posedge clk); #1 wb_idle();
`else
    chk("err_tied", {31'd0, arb_err}, 32'd0);
`endif

    @(negedge clk);
    @(negedge clk);
    chk("sb_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cfg_bus_arbiter.md
Name: cfg_bus_arbiter

Overview:
- Shares the single rapcores configuration-register port between two requesters: the management SoC Wishbone slave (wbs_*) and the SPI host word interface (spi_*).
- Sits between the user-project Wishbone pins and the rapcores register bank.
- Serialises accesses, arbitrates round-robin and returns read data and completion to the owning requester.

Parameters:
- ADDR_W, 6: register word-address width; the bank holds 2^ADDR_W 32-bit words.
- BASE_ADDR, 32'h3000_0000: Wishbone base address. A hit requires wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2].
- TIMEOUT, 255: maximum cycles to wait for reg_ready. Used only with the optional feature.

Ports:
- wb_clk_i in 1: single clock.
- wb_rst_ni in 1: reset, asynchronous, active-low.
- wbs_cyc_i, wbs_stb_i, wbs_we_i in 1 each: Wishbone classic strobes.
- wbs_sel_i in 4: Wishbone byte enables.
- wbs_adr_i in 32: Wishbone byte address.
- wbs_dat_i in 32: Wishbone write data.
- wbs_ack_o out 1: Wishbone acknowledge.
- wbs_dat_o out 32: Wishbone read data.
- spi_req in 1: SPI access request, level.
- spi_we in 1: SPI write enable.
- spi_addr in ADDR_W: SPI word address.
- spi_wdata in 32: SPI write data.
- spi_done out 1: SPI completion pulse.
- spi_rdata out 32: SPI read data.
- reg_en out 1: register-port access strobe.
- reg_we out 1: register-port write enable.
- reg_be out 4: register-port byte enables.
- reg_addr out ADDR_W: register-port word address.
- reg_wdata out 32: register-port write data.
- reg_rdata in 32: register-port read data.
- reg_ready in 1: register-port ready.
- arb_busy out 1: high when the FSM is not in IDLE.
- arb_owner out 1: 0 = Wishbone, 1 = SPI; valid while arb_busy is high.
- arb_err out 1: sticky timeout flag (optional feature).

Behaviour:
- Reset: asynchronous on wb_rst_ni low. All outputs go to 0 immediately, including reg_en. FSM returns to IDLE, rr_last = SPI, so Wishbone wins the first tie. Any in-flight transaction is dropped with no ack or done.
- All outputs are registered.
- wb_req = wbs_cyc_i & wbs_stb_i & address hit. Non-hit cycles are ignored and never acked.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Neither requester active: stay in IDLE.
  - One requester: grant it.
  - Both: grant the requester that is not rr_last.
  - On grant, latch owner, we, addr (wbs_adr_i[ADDR_W+1:2] or spi_addr), wdata and be (wbs_sel_i, or 4'hF for SPI). Update rr_last and go to ACCESS.
- ACCESS:
  - reg_en = 1 with the latched fields held stable.
  - When reg_ready is sampled high: capture reg_rdata (writes capture as well), drive reg_en = 0 on the next edge, go to RESP.
  - reg_ready high on the first ACCESS cycle is legal.
- RESP:
  - Owner WB: wbs_ack_o = 1 for exactly one cycle, wbs_dat_o = captured data. wbs_dat_o holds that value until the next WB response.
  - Owner SPI: spi_done = 1 for one cycle, spi_rdata = captured data, held likewise.
  - Return to IDLE.
- Minimum latency: request seen in IDLE at cycle 0, reg_en at cycle 1, ack/done at cycle 2 when reg_ready is high at cycle 1.
- Requester abandonment:
  - WB master drops wbs_cyc_i during ACCESS: the register access still completes; the ack is suppressed in RESP.
  - spi_req dropped during ACCESS: spi_done is still issued.
- Back-to-back requests: the WB master drops stb after the ack, so the IDLE cycle after RESP re-arbitrates with no double issue. A requester held continuously high alternates with a competing requester: WB, SPI, WB, …
- Starvation bound: a waiting requester is served after at most one transaction of the other requester.

Optional Feature:
- Macro: CFG_ARB_TIMEOUT_EN.
- Defined:
  - A counter (width $clog2(TIMEOUT+1)) clears on entry to ACCESS and increments each ACCESS cycle without reg_ready.
  - When the counter reaches TIMEOUT: reg_en drops, captured data = 32'hDEAD_BEEF, arb_err is set (sticky until reset), normal RESP follows.
  - reg_ready and timeout in the same cycle: reg_ready wins.
- Not defined: ACCESS waits indefinitely for reg_ready, no counter logic is built, and arb_err is tied to 0.

Test Plan:
- WB write, adr 0x3000_0008, dat 0x1234_5678, sel 4'b0011, reg_ready tied high: reg_addr = 2, reg_be = 4'b0011, reg_we = 1, reg_en high for one cycle, wbs_ack_o one cycle at cycle 2.
- SPI read, addr 5, reg_rdata 0xCAFE_0005, reg_ready delayed 3 cycles: spi_done one pulse, spi_rdata = 0xCAFE_0005, wbs_ack_o stays 0.
- WB and SPI both requesting continuously from reset: grants order WB, SPI, WB, SPI; arb_owner toggles each transaction; no gaps beyond one IDLE cycle.
- WB access to 0x2000_0000 (address miss): no reg_en, no ack, arb_busy stays 0.
- wb_rst_ni pulsed low mid-ACCESS: reg_en, arb_busy and wbs_ack_o go 0 asynchronously; after release, a new SPI request completes normally.
- With CFG_ARB_TIMEOUT_EN, TIMEOUT = 4, reg_ready held low: after 4 ACCESS cycles wbs_ack_o pulses with wbs_dat_o = 0xDEAD_BEEF and arb_err = 1; arb_err stays 1 through a subsequent good access.
